ysyx_22040127_div_ctrl: RTL

- EXU-side controller directly upstream of the 64-bit restoring divider (ysyx_22040127_div); consumes RV64M DIV/DIVU/REM/REMU and the W forms from the EXU.
- Prepares operands, handles the divide-by-zero and overflow special cases without the divider, and launches the divider with a one-cycle start pulse.
- Holds divider operands stable until completion, then selects quo or rem, applies W sign-extension, and presents the result to WBU with a valid/ready handshake.

---
 rtl/ysyx_22040127_div_ctrl.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ysyx_22040127_div_ctrl.sv
// ysyx_22040127_div_ctrl: EXU-side controller in front of the 64-bit restoring
// divider. Prepares operands for DIV/DIVU/REM/REMU and their W forms, resolves
// divide-by-zero and signed overflow locally, launches the divider with a
// one-cycle start pulse and hands the final rd value to WBU via valid/ready.
// Optional macro DIV_CTRL_REUSE_EN adds a one-entry quotient/remainder cache so
// that e.g. a REM following a DIV of the same operands skips the divider.
module ysyx_22040127_div_ctrl #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic            in_word,
  input  logic [XLEN-1:0] in_src1,
  input  logic [XLEN-1:0] in_src2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            busy,
  output logic [XLEN-1:0] div_x,
  output logic [XLEN-1:0] div_y,
  output logic            div_s,
  output logic            div_start,
  input  logic            div_ready,
  input  logic [XLEN-1:0] div_quo,
  input  logic [XLEN-1:0] div_rem
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DONE  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t          r_state;
  state_t          w_state_nx;

  logic [XLEN-1:0] r_x;
  logic [XLEN-1:0] r_y;
  logic            r_s;
  logic            r_start;
  logic            r_op_rem;
  logic            r_word;
  logic [XLEN-1:0] r_result;
  logic            r_mask;
  logic [6:0]      r_mask_cnt;

  logic            w_signed;
  logic            w_accept;
  logic            w_rdy;
  logic [XLEN-1:0] w_x;
  logic [XLEN-1:0] w_y;
  logic            w_divzero;
  logic            w_ovf;
  logic            w_special;
  logic [XLEN-1:0] w_spec_quo;
  logic [XLEN-1:0] w_spec_rem;
  logic            w_hit;
  logic [XLEN-1:0] w_hit_quo;
  logic [XLEN-1:0] w_hit_rem;
  logic            w_launch;
  logic            w_load_spec;
  logic            w_load_hit;
  logic            w_load_div;
  logic [XLEN-1:0] w_fin_quo;
  logic [XLEN-1:0] w_fin_rem;
  logic            w_fin_sel_rem;
  logic            w_fin_word;
  logic [XLEN-1:0] w_fin;

  // Pick quotient or remainder; W forms always sign-extend bit 31, even unsigned ones
  function automatic logic [XLEN-1:0] f_finish(input logic [XLEN-1:0] quo,
                                               input logic [XLEN-1:0] rem,
                                               input logic            sel_rem,
                                               input logic            word);
    logic [XLEN-1:0] sel;
    sel = sel_rem ? rem : quo;
    if (word) f_finish = {{(XLEN-32){sel[31]}}, sel[31:0]};
    else      f_finish = sel;
  endfunction

  assign w_signed = ~in_op[0];
  assign w_x = in_word ? {{(XLEN-32){w_signed & in_src1[31]}}, in_src1[31:0]} : in_src1;
  assign w_y = in_word ? {{(XLEN-32){w_signed & in_src2[31]}}, in_src2[31:0]} : in_src2;

  assign in_ready = (r_state == S_IDLE) & ~flush;
  assign w_accept = in_valid & in_ready;
  assign w_rdy    = div_ready & ~r_mask;

  assign w_divzero  = (w_y == '0);
  assign w_ovf      = w_signed & (w_x == MIN_NEG) & (w_y == '1);
  assign w_special  = w_divzero | w_ovf;
  assign w_spec_quo = w_divzero ? '1 : w_x;
  assign w_spec_rem = w_divzero ? w_x : '0;

`ifdef DIV_CTRL_REUSE_EN
  logic            r_c_valid;
  logic [XLEN-1:0] r_c_x;
  logic [XLEN-1:0] r_c_y;
  logic            r_c_s;
  logic            r_c_word;
  logic [XLEN-1:0] r_c_quo;
  logic [XLEN-1:0] r_c_rem;

  // Remember the last completed divide so an identical follow-up can skip the divider
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_c_valid <= 1'b0;
      r_c_x     <= '0;
      r_c_y     <= '0;
      r_c_s     <= 1'b0;
      r_c_word  <= 1'b0;
      r_c_quo   <= '0;
      r_c_rem   <= '0;
    end else if (w_load_div) begin
      r_c_valid <= 1'b1;
      r_c_x     <= r_x;
      r_c_y     <= r_y;
      r_c_s     <= r_s;
      r_c_word  <= r_word;
      r_c_quo   <= div_quo;
      r_c_rem   <= div_rem;
    end
  end

  assign w_hit = r_c_valid & (r_c_x == w_x) & (r_c_y == w_y) &
                 (r_c_s == w_signed) & (r_c_word == in_word);
  assign w_hit_quo = r_c_quo;
  assign w_hit_rem = r_c_rem;
`else
  assign w_hit     = 1'b0;
  assign w_hit_quo = '0;
  assign w_hit_rem = '0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nx;
  end

  // Next state and the one-cycle load/launch strobes
  always_comb begin
    w_state_nx  = r_state;
    w_launch    = 1'b0;
    w_load_spec = 1'b0;
    w_load_hit  = 1'b0;
    w_load_div  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_special) begin
            w_load_spec = 1'b1;
            w_state_nx  = S_DONE;
          end else if (w_hit) begin
            w_load_hit = 1'b1;
            w_state_nx = S_DONE;
          end else begin
            w_launch   = 1'b1;
            w_state_nx = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (flush) begin
          w_state_nx = w_rdy ? S_IDLE : S_DRAIN;
        end else if (w_rdy) begin
          w_load_div = 1'b1;
          w_state_nx = S_DONE;
        end
      end
      S_DRAIN: begin
        if (w_rdy) w_state_nx = S_IDLE;
      end
      S_DONE: begin
        if (flush || out_ready) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Result source: divider output in WAIT, otherwise the local special/cached values
  always_comb begin
    w_fin_quo     = w_spec_quo;
    w_fin_rem     = w_spec_rem;
    w_fin_sel_rem = in_op[1];
    w_fin_word    = in_word;
    if (w_load_div) begin
      w_fin_quo     = div_quo;
      w_fin_rem     = div_rem;
      w_fin_sel_rem = r_op_rem;
      w_fin_word    = r_word;
    end else if (w_load_hit) begin
      w_fin_quo = w_hit_quo;
      w_fin_rem = w_hit_rem;
    end
  end

  assign w_fin = f_finish(w_fin_quo, w_fin_rem, w_fin_sel_rem, w_fin_word);

  // Operands are captured only at accept so they stay put while the divider runs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_x      <= '0;
      r_y      <= '0;
      r_s      <= 1'b0;
      r_op_rem <= 1'b0;
      r_word   <= 1'b0;
      r_start  <= 1'b0;
      r_result <= '0;
    end else begin
      r_start <= w_launch;
      if (w_accept) begin
        r_x      <= w_x;
        r_y      <= w_y;
        r_s      <= w_signed;
        r_op_rem <= in_op[1];
        r_word   <= in_word;
      end
      if (w_load_spec || w_load_hit || w_load_div) r_result <= w_fin;
    end
  end

  // After reset, swallow the completion of whatever the divider was still running
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mask     <= 1'b1;
      r_mask_cnt <= '0;
    end else if (r_mask) begin
      if (div_ready || r_mask_cnt == 7'd69) r_mask <= 1'b0;
      else                                  r_mask_cnt <= r_mask_cnt + 7'd1;
    end
  end

  assign out_valid  = (r_state == S_DONE);
  assign busy       = (r_state != S_IDLE);
  assign out_result = r_result;
  assign div_x      = r_x;
  assign div_y      = r_y;
  assign div_s      = r_s;
  assign div_start  = r_start;

endmodule
